cpu_core_param: RTL and testbench



---
 rtl/cpu_core_param.sv | 202 ++++++++++++++++++++
 tb/tb_cpu_core_param.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_param.sv
// Multicycle accumulator CPU with req/ack instruction and data ports.
// Width-generic successor of the tp1 core; adds HALT and a MEM-skip path.
module cpu_core_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              _iClk,
    input  logic              _iReset,
    output logic [ADDR_W-1:0] _oInstMemAddr,
    output logic              _oInstMemReq,
    input  logic              _iInstMemAck,
    input  logic [DATA_W-1:0] _iInstMemData,
    output logic [ADDR_W-1:0] _oDataMemAddr,
    output logic [DATA_W-1:0] _oDataMemWData,
    output logic              _oDataMemWrite,
    output logic              _oDataMemReq,
    input  logic              _iDataMemAck,
    input  logic [DATA_W-1:0] _iDataMemRData,
    output logic              _oHalted,
    output logic [DATA_W-1:0] _oAcc,
    output logic [2:0]        _oFlags
);

    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_ADDC  = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd5;
    localparam logic [3:0] OP_SUBC  = 4'd6;
    localparam logic [3:0] OP_AND   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_XOR   = 4'd9;
    localparam logic [3:0] OP_JUMP  = 4'd10;
    localparam logic [3:0] OP_JZ    = 4'd11;
    localparam logic [3:0] OP_JC    = 4'd12;
    localparam logic [3:0] OP_JN    = 4'd13;
    localparam logic [3:0] OP_HALT  = 4'd14;

    typedef enum logic [2:0] {
        ST_IF,
        ST_AF,
        ST_MEM,
        ST_EXWB,
        ST_HALT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] arg;
    logic [DATA_W-1:0] memData;
    logic [4:0]        inst;
    logic              flagN;
    logic              flagC;
    logic              flagZ;

    logic [3:0]        opcode;
    logic              immBit;
    logic              isAlu;
    logic              isStore;
    logic              needMem;
    logic [DATA_W-1:0] opB;
    logic [DATA_W:0]   aluWide;
    logic [DATA_W-1:0] aluRes;
    logic              aluC;
    logic              aluWe;
    logic              loadWe;
    logic              jumpTaken;
    logic [ADDR_W-1:0] pcPlus2;
    logic [ADDR_W-1:0] pcNext;
    logic [DATA_W:0]   carryIn;

    assign opcode  = inst[3:0];
    assign immBit  = inst[4];
    assign isAlu   = (opcode >= OP_ADD) && (opcode <= OP_XOR);
    assign isStore = (opcode == OP_STORE);
    assign needMem = isStore || (!immBit && (opcode == OP_LOAD || isAlu));
    assign opB     = immBit ? arg : memData;
    assign carryIn = {{DATA_W{1'b0}}, flagC};

    always_comb begin
        aluWide = '0;
        aluWe   = 1'b0;
        loadWe  = 1'b0;
        unique case (opcode)
            OP_LOAD: loadWe = 1'b1;
            OP_ADD:  begin aluWide = {1'b0, acc} + {1'b0, opB}; aluWe = 1'b1; end
            OP_ADDC: begin aluWide = {1'b0, acc} + {1'b0, opB} + carryIn; aluWe = 1'b1; end
            OP_SUB:  begin aluWide = {1'b0, acc} - {1'b0, opB}; aluWe = 1'b1; end
            OP_SUBC: begin aluWide = {1'b0, acc} - {1'b0, opB} - carryIn; aluWe = 1'b1; end
            OP_AND:  begin aluWide = {1'b0, acc & opB}; aluWe = 1'b1; end
            OP_OR:   begin aluWide = {1'b0, acc | opB}; aluWe = 1'b1; end
            OP_XOR:  begin aluWide = {1'b0, acc ^ opB}; aluWe = 1'b1; end
            default: aluWide = '0;
        endcase
    end

    // Bit DATA_W is carry for adds and borrow for subtracts; logic ops clear it.
    assign aluRes = aluWide[DATA_W-1:0];
    assign aluC   = aluWide[DATA_W];

    always_comb begin
        jumpTaken = 1'b0;
        unique case (1'b1)
            opcode == OP_JUMP: jumpTaken = 1'b1;
            opcode == OP_JZ:   jumpTaken = flagZ;
            opcode == OP_JC:   jumpTaken = flagC;
            opcode == OP_JN:   jumpTaken = flagN;
            default:           jumpTaken = 1'b0;
        endcase
    end

    assign pcPlus2 = pc + ADDR_W'(2);
    assign pcNext  = jumpTaken ? pcPlus2 + arg[ADDR_W-1:0] : pcPlus2;

    always_ff @(posedge _iClk) begin
        if (_iReset) begin
            state          <= ST_IF;
            pc             <= '0;
            acc            <= '0;
            arg            <= '0;
            memData        <= '0;
            inst           <= '0;
            flagN          <= 1'b0;
            flagC          <= 1'b0;
            flagZ          <= 1'b1;
            _oInstMemReq   <= 1'b1;
            _oInstMemAddr  <= '0;
            _oDataMemReq   <= 1'b0;
            _oDataMemAddr  <= '0;
            _oDataMemWData <= '0;
            _oDataMemWrite <= 1'b0;
            _oHalted       <= 1'b0;
        end else begin
            unique case (state)
                ST_IF: begin
                    if (_oInstMemReq && _iInstMemAck) begin
                        inst          <= _iInstMemData[4:0];
                        _oInstMemAddr <= pc + ADDR_W'(1);
                        state         <= ST_AF;
                    end
                end
                ST_AF: begin
                    if (_oInstMemReq && _iInstMemAck) begin
                        arg          <= _iInstMemData;
                        _oInstMemReq <= 1'b0;
                        if (needMem) begin
                            _oDataMemReq   <= 1'b1;
                            _oDataMemWrite <= isStore;
                            // Immediate store swaps roles: acc is the address.
                            if (isStore && immBit) begin
                                _oDataMemAddr  <= acc[ADDR_W-1:0];
                                _oDataMemWData <= _iInstMemData;
                            end else begin
                                _oDataMemAddr  <= _iInstMemData[ADDR_W-1:0];
                                _oDataMemWData <= acc;
                            end
                            state <= ST_MEM;
                        end else begin
                            state <= ST_EXWB;
                        end
                    end
                end
                ST_MEM: begin
                    if (_oDataMemReq && _iDataMemAck) begin
                        memData        <= _iDataMemRData;
                        _oDataMemReq   <= 1'b0;
                        _oDataMemWrite <= 1'b0;
                        _oDataMemAddr  <= '0;
                        _oDataMemWData <= '0;
                        state          <= ST_EXWB;
                    end
                end
                ST_EXWB: begin
                    if (aluWe) begin
                        acc   <= aluRes;
                        flagC <= aluC;
                        flagZ <= (aluRes == '0);
                        flagN <= aluRes[DATA_W-1];
                    end else if (loadWe) begin
                        acc <= opB;
                    end
                    pc <= pcNext;
                    if (opcode == OP_HALT) begin
                        _oHalted <= 1'b1;
                        state    <= ST_HALT;
                    end else begin
                        _oInstMemReq  <= 1'b1;
                        _oInstMemAddr <= pcNext;
                        state         <= ST_IF;
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IF;
            endcase
        end
    end

    assign _oAcc   = acc;
    assign _oFlags = {flagN, flagC, flagZ};

endmodule

// File: tb/tb_cpu_core_param.sv
// Scoreboard bench for cpu_core_param: 8-bit core with wait-state memories
// and a 16/10-bit core on a zero-wait ROM.
module tb_cpu_core_param;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] acc;
        logic [2:0]  flags;
        int          delta;
    } fexp_t;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } dexp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit monEn = 1'b0;

    logic       rst8;
    logic [7:0] iAddr8, iData8, dAddr8, dWData8, dRData8, acc8;
    logic       iReq8, iAck8, dWrite8, dReq8, dAck8, halt8;
    logic [2:0] flags8;

    logic        rst16;
    logic [9:0]  iAddr16, dAddr16;
    logic [15:0] iData16, dWData16, dRData16, acc16;
    logic        iReq16, iAck16, dWrite16, dReq16, dAck16, halt16;
    logic [2:0]  flags16;

    cpu_core_param #(.DATA_W(8), .ADDR_W(8)) u8 (
        ._iClk(clk), ._iReset(rst8),
        ._oInstMemAddr(iAddr8), ._oInstMemReq(iReq8),
        ._iInstMemAck(iAck8), ._iInstMemData(iData8),
        ._oDataMemAddr(dAddr8), ._oDataMemWData(dWData8),
        ._oDataMemWrite(dWrite8), ._oDataMemReq(dReq8),
        ._iDataMemAck(dAck8), ._iDataMemRData(dRData8),
        ._oHalted(halt8), ._oAcc(acc8), ._oFlags(flags8)
    );

    cpu_core_param #(.DATA_W(16), .ADDR_W(10)) u16 (
        ._iClk(clk), ._iReset(rst16),
        ._oInstMemAddr(iAddr16), ._oInstMemReq(iReq16),
        ._iInstMemAck(iAck16), ._iInstMemData(iData16),
        ._oDataMemAddr(dAddr16), ._oDataMemWData(dWData16),
        ._oDataMemWrite(dWrite16), ._oDataMemReq(dReq16),
        ._iDataMemAck(dAck16), ._iDataMemRData(dRData16),
        ._oHalted(halt16), ._oAcc(acc16), ._oFlags(flags16)
    );

    logic [7:0]  rom8 [256];
    logic [7:0]  ram8 [256];
    logic [15:0] rom16 [1024];
    fexp_t fq8[$];
    fexp_t fq16[$];
    dexp_t dq8[$];

    int iWait8 = 0, dWait8 = 0;
    int iCnt8 = 0, dCnt8 = 0, dHeld8 = 0;
    int cyc8 = 0, lastF8 = 0, cyc16 = 0, lastF16 = 0;
    logic [7:0] ackA8, ackDA8, ackDW8;
    logic       ackDWr8;
    logic [9:0] ackA16;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pf8(input logic [15:0] a, input logic [15:0] acc,
                       input logic [2:0] f, input int d);
        fexp_t e;
        e.addr = a; e.acc = acc; e.flags = f; e.delta = d;
        fq8.push_back(e);
    endtask

    task automatic pf16(input logic [15:0] a, input logic [15:0] acc,
                        input logic [2:0] f, input int d);
        fexp_t e;
        e.addr = a; e.acc = acc; e.flags = f; e.delta = d;
        fq16.push_back(e);
    endtask

    task automatic pd8(input logic wr, input logic [15:0] a,
                       input logic [15:0] w);
        dexp_t e;
        e.wr = wr; e.addr = a; e.wdata = w;
        dq8.push_back(e);
    endtask

    task automatic w8(input logic [7:0] a, input logic [7:0] op,
                      input logic [7:0] arg);
        rom8[a] = op;
        rom8[8'(a + 8'd1)] = arg;
    endtask

    // 8-bit instruction ROM model and fetch monitor
    always @(negedge clk) begin
        fexp_t e;
        cyc8++;
        if (rst8) begin
            iAck8 = 1'b0;
            iCnt8 = 0;
        end else begin
            if (iAck8) begin
                if (monEn) begin
                    if (fq8.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL fetch8_unexpected addr=%h", ackA8);
                    end else begin
                        e = fq8.pop_front();
                        chk("fetch8_addr", 32'(ackA8), 32'(e.addr));
                        chk("fetch8_acc", 32'(acc8), 32'(e.acc));
                        chk("fetch8_flags", 32'(flags8), 32'(e.flags));
                        if (e.delta >= 0)
                            chk("fetch8_cycles", 32'(cyc8 - lastF8), 32'(e.delta));
                    end
                end
                lastF8 = cyc8;
                iCnt8 = 0;
            end
            iAck8 = 1'b0;
            if (iReq8) begin
                if (iCnt8 >= iWait8) begin
                    iAck8 = 1'b1;
                    iData8 = rom8[iAddr8];
                    ackA8 = iAddr8;
                end else begin
                    iCnt8++;
                end
            end
        end
    end

    // 8-bit data RAM model and transfer monitor
    always @(negedge clk) begin
        dexp_t e;
        if (rst8) begin
            dAck8 = 1'b0;
            dCnt8 = 0;
            dHeld8 = 0;
        end else begin
            if (dAck8) begin
                if (monEn) begin
                    if (dq8.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL data8_unexpected addr=%h", ackDA8);
                    end else begin
                        e = dq8.pop_front();
                        chk("data8_write", 32'(ackDWr8), 32'(e.wr));
                        chk("data8_addr", 32'(ackDA8), 32'(e.addr));
                        if (e.wr)
                            chk("data8_wdata", 32'(ackDW8), 32'(e.wdata));
                        chk("data8_held", 32'(dHeld8), 32'(dWait8 + 1));
                    end
                end
                dCnt8 = 0;
                dHeld8 = 0;
            end
            dAck8 = 1'b0;
            if (dReq8) begin
                dHeld8++;
                if (dCnt8 >= dWait8) begin
                    dAck8 = 1'b1;
                    ackDA8 = dAddr8;
                    ackDW8 = dWData8;
                    ackDWr8 = dWrite8;
                    if (dWrite8) ram8[dAddr8] = dWData8;
                    else dRData8 = ram8[dAddr8];
                end else begin
                    dCnt8++;
                end
            end
        end
    end

    // 16-bit zero-wait ROM model and fetch monitor
    always @(negedge clk) begin
        fexp_t e;
        cyc16++;
        if (rst16) begin
            iAck16 = 1'b0;
        end else begin
            if (iAck16) begin
                if (fq16.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL fetch16_unexpected addr=%h", ackA16);
                end else begin
                    e = fq16.pop_front();
                    chk("fetch16_addr", 32'(ackA16), 32'(e.addr));
                    chk("fetch16_acc", 32'(acc16), 32'(e.acc));
                    chk("fetch16_flags", 32'(flags16), 32'(e.flags));
                    if (e.delta >= 0)
                        chk("fetch16_cycles", 32'(cyc16 - lastF16), 32'(e.delta));
                end
                lastF16 = cyc16;
            end
            iAck16 = 1'b0;
            if (iReq16) begin
                iAck16 = 1'b1;
                iData16 = rom16[iAddr16];
                ackA16 = iAddr16;
            end
        end
    end

    initial begin
        int n;
        rst8 = 1'b1; rst16 = 1'b1;
        iData8 = '0; dRData8 = '0; iAck8 = 1'b0; dAck8 = 1'b0;
        iData16 = '0; iAck16 = 1'b0; dAck16 = 1'b0; dRData16 = '0;
        ackA8 = '0; ackDA8 = '0; ackDW8 = '0; ackDWr8 = 1'b0; ackA16 = '0;
        foreach (rom8[i]) rom8[i] = 8'h00;
        foreach (ram8[i]) ram8[i] = 8'h00;
        foreach (rom16[i]) rom16[i] = 16'h0000;

        // Program A: ALU immediates, STORE/LOAD through a 2-wait RAM
        w8(8'h00, 8'h11, 8'h05); w8(8'h02, 8'h13, 8'hFB);
        w8(8'h04, 8'h11, 8'h7F); w8(8'h06, 8'h02, 8'h10);
        w8(8'h08, 8'h01, 8'h10); w8(8'h0A, 8'h12, 8'h55);
        w8(8'h0C, 8'h03, 8'h7F); w8(8'h0E, 8'h0E, 8'h00);
        pf8(16'h00, 16'h00, 3'b001, -1); pf8(16'h01, 16'h00, 3'b001, 1);
        pf8(16'h02, 16'h05, 3'b001, 2);  pf8(16'h03, 16'h05, 3'b001, 1);
        pf8(16'h04, 16'h00, 3'b011, 2);  pf8(16'h05, 16'h00, 3'b011, 1);
        pf8(16'h06, 16'h7F, 3'b011, 2);  pf8(16'h07, 16'h7F, 3'b011, 1);
        pf8(16'h08, 16'h7F, 3'b011, 5);  pf8(16'h09, 16'h7F, 3'b011, 1);
        pf8(16'h0A, 16'h7F, 3'b011, 5);  pf8(16'h0B, 16'h7F, 3'b011, 1);
        pf8(16'h0C, 16'h7F, 3'b011, 5);  pf8(16'h0D, 16'h7F, 3'b011, 1);
        pf8(16'h0E, 16'hD4, 3'b100, 5);  pf8(16'h0F, 16'hD4, 3'b100, 1);
        pd8(1'b1, 16'h10, 16'h7F); pd8(1'b0, 16'h10, 16'h00);
        pd8(1'b1, 16'h7F, 16'h55); pd8(1'b0, 16'h7F, 16'h00);

        step(); step();
        chk("rst_ireq", 32'(iReq8), 32'd1);
        chk("rst_iaddr", 32'(iAddr8), 32'd0);
        chk("rst_dreq", 32'(dReq8), 32'd0);
        chk("rst_daddr", 32'(dAddr8), 32'd0);
        chk("rst_dwdata", 32'(dWData8), 32'd0);
        chk("rst_dwrite", 32'(dWrite8), 32'd0);
        chk("rst_halted", 32'(halt8), 32'd0);
        chk("rst_acc", 32'(acc8), 32'd0);
        chk("rst_flags", 32'(flags8), 32'b001);
        monEn = 1'b1; dWait8 = 2; rst8 = 1'b0;
        n = 0;
        while (!halt8 && n < 400) begin step(); n++; end
        chk("A_halted", 32'(halt8), 32'd1);
        chk("A_acc", 32'(acc8), 32'hD4);
        chk("A_flags", 32'(flags8), 32'b100);
        chk("A_ram10", 32'(ram8[8'h10]), 32'h7F);
        chk("A_fq_left", 32'(fq8.size()), 32'd0);
        chk("A_dq_left", 32'(dq8.size()), 32'd0);

        // Program B: jumps with wrap, JZ both ways, SUB/SUBC borrow chain
        rst8 = 1'b1;
        foreach (rom8[i]) rom8[i] = 8'h00;
        w8(8'h00, 8'h0A, 8'hFC); w8(8'hFE, 8'h0A, 8'h10);
        w8(8'h10, 8'h13, 8'h01); w8(8'h12, 8'h0B, 8'h40);
        w8(8'h14, 8'h0A, 8'h08); w8(8'h1E, 8'h15, 8'h01);
        w8(8'h20, 8'h0B, 8'h04); w8(8'h26, 8'h15, 8'h01);
        w8(8'h28, 8'h16, 8'h00); w8(8'h2A, 8'h0E, 8'h00);
        pf8(16'h00, 16'h00, 3'b001, -1); pf8(16'h01, 16'h00, 3'b001, 1);
        pf8(16'hFE, 16'h00, 3'b001, 2);  pf8(16'hFF, 16'h00, 3'b001, 1);
        pf8(16'h10, 16'h00, 3'b001, 2);  pf8(16'h11, 16'h00, 3'b001, 1);
        pf8(16'h12, 16'h01, 3'b000, 2);  pf8(16'h13, 16'h01, 3'b000, 1);
        pf8(16'h14, 16'h01, 3'b000, 2);  pf8(16'h15, 16'h01, 3'b000, 1);
        pf8(16'h1E, 16'h01, 3'b000, 2);  pf8(16'h1F, 16'h01, 3'b000, 1);
        pf8(16'h20, 16'h00, 3'b001, 2);  pf8(16'h21, 16'h00, 3'b001, 1);
        pf8(16'h26, 16'h00, 3'b001, 2);  pf8(16'h27, 16'h00, 3'b001, 1);
        pf8(16'h28, 16'hFF, 3'b110, 2);  pf8(16'h29, 16'hFF, 3'b110, 1);
        pf8(16'h2A, 16'hFE, 3'b100, 2);  pf8(16'h2B, 16'hFE, 3'b100, 1);
        step(); step();
        rst8 = 1'b0;
        n = 0;
        while (!halt8 && n < 400) begin step(); n++; end
        chk("B_halted", 32'(halt8), 32'd1);
        chk("B_acc", 32'(acc8), 32'hFE);
        chk("B_flags", 32'(flags8), 32'b100);
        chk("B_fq_left", 32'(fq8.size()), 32'd0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (iReq8 || dReq8) n++;
        end
        chk("halt_noreq", 32'(n), 32'd0);
        chk("halt_held", 32'(halt8), 32'd1);

        // Reset while the ROM stalls the fetch at 0xFE
        monEn = 1'b0;
        rst8 = 1'b1; step(); step();
        rst8 = 1'b0;
        step(); step(); step();
        iWait8 = 50;
        step(); step(); step();
        chk("stall_ireq", 32'(iReq8), 32'd1);
        chk("stall_iaddr", 32'(iAddr8), 32'hFE);
        rst8 = 1'b1; step();
        rst8 = 1'b0;
        chk("rstmid_ireq", 32'(iReq8), 32'd1);
        chk("rstmid_iaddr", 32'(iAddr8), 32'h00);
        chk("rstmid_halted", 32'(halt8), 32'd0);
        chk("rstmid_acc", 32'(acc8), 32'h00);
        step();
        chk("rstmid_ireq2", 32'(iReq8), 32'd1);
        chk("rstmid_iaddr2", 32'(iAddr8), 32'h00);

        // 16-bit core: carry out of 0xFFFF and 10-bit pc wrap
        rom16[0] = 16'h0011; rom16[1] = 16'h0001;
        rom16[2] = 16'h0013; rom16[3] = 16'hFFFF;
        rom16[4] = 16'h000A; rom16[5] = 16'hFFF0;
        rom16[10'h3F6] = 16'h000E; rom16[10'h3F7] = 16'h0000;
        pf16(16'h000, 16'h0000, 3'b001, -1); pf16(16'h001, 16'h0000, 3'b001, 1);
        pf16(16'h002, 16'h0001, 3'b001, 2);  pf16(16'h003, 16'h0001, 3'b001, 1);
        pf16(16'h004, 16'h0000, 3'b011, 2);  pf16(16'h005, 16'h0000, 3'b011, 1);
        pf16(16'h3F6, 16'h0000, 3'b011, 2);  pf16(16'h3F7, 16'h0000, 3'b011, 1);
        step();
        rst16 = 1'b0;
        n = 0;
        while (!halt16 && n < 200) begin step(); n++; end
        chk("W_halted", 32'(halt16), 32'd1);
        chk("W_acc", 32'(acc16), 32'h0000);
        chk("W_flags", 32'(flags16), 32'b011);
        chk("W_dreq", 32'(dReq16), 32'd0);
        chk("W_fq_left", 32'(fq16.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
